// File: rtl/i2c_master_burst_ctrl.sv
// Multi-byte I2C transfer sequencer driving i2c_master_byte_ctrl: START, address, write burst from
// TX FIFO, optional repeated-START read burst into RX FIFO, STOP.
module i2c_master_burst_ctrl #(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [6:0]       addr_i,
  input  logic [LEN_W-1:0] wr_len_i,
  input  logic [LEN_W-1:0] rd_len_i,
  input  logic             tx_we,
  input  logic [7:0]       tx_data,
  output logic             tx_full,
  input  logic             rx_re,
  output logic [7:0]       rx_data,
  output logic             rx_empty,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             bc_start,
  output logic             bc_stop,
  output logic             bc_read,
  output logic             bc_write,
  output logic             bc_ack_in,
  output logic [7:0]       bc_din,
  input  logic             bc_cmd_ack,
  input  logic             bc_ack_out,
  input  logic [7:0]       bc_dout
);
  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = 1;
  localparam logic [LEN_W-1:0] LenOne = 1;

  typedef enum logic [2:0] {StIdle, StAddrW, StWdata, StAddrR, StRdata, StStop, StDone} state_e;
  state_e state_q, state_d;

  logic [7:0]       tx_mem [Depth];
  logic [7:0]       rx_mem [Depth];
  logic [FIFO_AW:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic             tx_empty, rx_full, tx_push, rx_pop, tx_pop, tx_flush, rx_push;

  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic             nack_q, nack_d, abort_q, abort_d, pend_q, pend_d;
  logic             start_q, start_d, stop_q, stop_d, read_q, read_d, write_q, write_d;
  logic             ack_in_q, ack_in_d;
  logic [7:0]       din_q, din_d;
  logic             cmd_done;
  state_e           after_stop;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[FIFO_AW] != tx_rptr_q[FIFO_AW]) &&
                    (tx_wptr_q[FIFO_AW-1:0] == tx_rptr_q[FIFO_AW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[FIFO_AW] != rx_rptr_q[FIFO_AW]) &&
                    (rx_wptr_q[FIFO_AW-1:0] == rx_rptr_q[FIFO_AW-1:0]);
  assign tx_push  = tx_we & ~tx_full;
  assign rx_pop   = rx_re & ~rx_empty;
  assign rx_data  = rx_mem[rx_rptr_q[FIFO_AW-1:0]];

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign nack_err  = nack_q;
  assign bc_start  = start_q;
  assign bc_stop   = stop_q;
  assign bc_read   = read_q;
  assign bc_write  = write_q;
  assign bc_ack_in = ack_in_q;
  assign bc_din    = din_q;

  assign cmd_done   = pend_q & bc_cmd_ack;
  // A command that already carried STOP leaves the bus released, so skip the STOP state.
  assign after_stop = stop_q ? StDone : StStop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[FIFO_AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wptr_q[FIFO_AW-1:0]] <= bc_dout;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    nack_d   = nack_q;
    abort_d  = abort_q;
    pend_d   = pend_q;
    start_d  = start_q;
    stop_d   = stop_q;
    read_d   = read_q;
    write_d  = write_q;
    ack_in_d = ack_in_q;
    din_d    = din_q;
    tx_pop   = 1'b0;
    tx_flush = 1'b0;
    rx_push  = 1'b0;

    // Drop command lines right after the ack so byte_ctrl does not re-trigger.
    if (cmd_done) begin
      pend_d   = 1'b0;
      start_d  = 1'b0;
      stop_d   = 1'b0;
      read_d   = 1'b0;
      write_d  = 1'b0;
      ack_in_d = 1'b0;
      din_d    = 8'h00;
    end

    if ((state_q == StIdle) || (state_q == StDone)) abort_d = 1'b0;
    else if (abort_i) abort_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = addr_i;
          wcnt_d  = wr_len_i;
          rcnt_d  = rd_len_i;
          nack_d  = 1'b0;
          state_d = ((wr_len_i == '0) && (rd_len_i != '0)) ? StAddrR : StAddrW;
        end
      end
      StAddrW: begin
        if (!pend_q) begin
          pend_d  = 1'b1;
          start_d = 1'b1;
          write_d = 1'b1;
          stop_d  = (wcnt_q == '0) && (rcnt_q == '0);
          din_d   = {addr_q, 1'b0};
        end else if (cmd_done) begin
          if (bc_ack_out) nack_d = 1'b1;
          if (bc_ack_out || abort_q) state_d = after_stop;
          else if (wcnt_q == '0) state_d = StDone;
          else state_d = StWdata;
        end
      end
      StWdata: begin
        if (!pend_q) begin
          if (tx_empty) begin
            if (abort_q) state_d = StStop;
          end else begin
            pend_d  = 1'b1;
            write_d = 1'b1;
            stop_d  = (wcnt_q == LenOne) && (rcnt_q == '0);
            din_d   = tx_mem[tx_rptr_q[FIFO_AW-1:0]];
          end
        end else if (cmd_done) begin
          tx_pop = 1'b1;
          wcnt_d = wcnt_q - LenOne;
          if (bc_ack_out) begin
            nack_d   = 1'b1;
            tx_flush = 1'b1;
            state_d  = after_stop;
          end else if (abort_q) begin
            state_d = after_stop;
          end else if (wcnt_q == LenOne) begin
            state_d = (rcnt_q == '0) ? StDone : StAddrR;
          end
        end
      end
      StAddrR: begin
        if (!pend_q) begin
          pend_d  = 1'b1;
          start_d = 1'b1;
          write_d = 1'b1;
          din_d   = {addr_q, 1'b1};
        end else if (cmd_done) begin
          if (bc_ack_out) nack_d = 1'b1;
          state_d = (bc_ack_out || abort_q) ? StStop : StRdata;
        end
      end
      StRdata: begin
        if (!pend_q) begin
          if (rx_full) begin
            if (abort_q) state_d = StStop;
          end else begin
            pend_d   = 1'b1;
            read_d   = 1'b1;
            ack_in_d = (rcnt_q == LenOne);
            stop_d   = (rcnt_q == LenOne);
          end
        end else if (cmd_done) begin
          rx_push = 1'b1;
          rcnt_d  = rcnt_q - LenOne;
          if (rcnt_q == LenOne) state_d = StDone;
          else if (abort_q) state_d = StStop;
        end
      end
      StStop: begin
        if (!pend_q) begin
          pend_d = 1'b1;
          stop_d = 1'b1;
        end else if (cmd_done) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      nack_q    <= 1'b0;
      abort_q   <= 1'b0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      ack_in_q  <= 1'b0;
      din_q     <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      nack_q   <= nack_d;
      abort_q  <= abort_d;
      pend_q   <= pend_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      read_q   <= read_d;
      write_q  <= write_d;
      ack_in_q <= ack_in_d;
      din_q    <= din_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
      // Flush discards everything queued before this cycle's push.
      if (tx_flush) tx_rptr_q <= tx_wptr_q;
      else if (tx_pop) tx_rptr_q <= tx_rptr_q + PtrOne;
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + PtrOne;
    end
  end
endmodule

// File: tb/tb_i2c_master_burst_ctrl.sv
// Scoreboard bench for i2c_master_burst_ctrl with a behavioural byte_ctrl responder.
module tb_i2c_master_burst_ctrl;
  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       start_i = 1'b0, abort_i = 1'b0;
  logic [6:0] addr_i = '0;
  logic [7:0] wr_len_i = '0, rd_len_i = '0;
  logic       tx_we = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_full, rx_empty, busy, done, nack_err;
  logic       rx_re = 1'b0;
  logic [7:0] rx_data;
  logic       bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0] bc_din;
  logic       bc_cmd_ack = 1'b0, bc_ack_out = 1'b0;
  logic [7:0] bc_dout = '0;

  int errors = 0;
  int checks = 0;
  int cmd_seen = 0;

  logic [12:0] exp_cmd [$];
  logic [7:0]  exp_rx [$];
  logic        nack_q [$];
  logic [7:0]  rd_q [$];

  always #5 clk = ~clk;

  i2c_master_burst_ctrl dut (
    .clk(clk), .nReset(nReset), .start_i(start_i), .abort_i(abort_i), .addr_i(addr_i),
    .wr_len_i(wr_len_i), .rd_len_i(rd_len_i), .tx_we(tx_we), .tx_data(tx_data),
    .tx_full(tx_full), .rx_re(rx_re), .rx_data(rx_data), .rx_empty(rx_empty), .busy(busy),
    .done(done), .nack_err(nack_err), .bc_start(bc_start), .bc_stop(bc_stop),
    .bc_read(bc_read), .bc_write(bc_write), .bc_ack_in(bc_ack_in), .bc_din(bc_din),
    .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout)
  );

  function automatic logic [12:0] cmd(logic s, logic p, logic r, logic w, logic ai, logic [7:0] d);
    return {s, p, r, w, ai, d};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each newly presented command against the scoreboard.
  initial begin
    logic prev_any = 1'b0;
    logic any;
    forever begin
      @(negedge clk);
      any = bc_start | bc_stop | bc_read | bc_write;
      if (any && !prev_any) begin
        cmd_seen++;
        if (exp_cmd.size() == 0) begin
          check("unexpected_cmd", {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}, 0);
        end else begin
          check("cmd", {bc_start, bc_stop, bc_read, bc_write, bc_read & bc_ack_in,
                        bc_write ? bc_din : 8'h00}, exp_cmd.pop_front());
        end
      end
      if (rx_re && !rx_empty) begin
        if (exp_rx.size() == 0) check("unexpected_rx", rx_data, 0);
        else check("rx_data", rx_data, exp_rx.pop_front());
      end
      prev_any = any;
    end
  end

  // byte_ctrl responder: acks each command two cycles after it appears.
  initial begin
    logic is_w, is_r;
    forever begin
      @(negedge clk);
      if (bc_start | bc_stop | bc_read | bc_write) begin
        is_w = bc_write;
        is_r = bc_read;
        repeat (2) @(negedge clk);
        bc_ack_out = 1'b0;
        bc_dout    = 8'h00;
        if (is_w && nack_q.size() != 0) bc_ack_out = nack_q.pop_front();
        if (is_r && rd_q.size() != 0) bc_dout = rd_q.pop_front();
        bc_cmd_ack = 1'b1;
        @(negedge clk);
        bc_cmd_ack = 1'b0;
        bc_ack_out = 1'b0;
      end
    end
  end

  task automatic push_tx(logic [7:0] d);
    @(posedge clk); #1;
    tx_we = 1'b1; tx_data = d;
    @(posedge clk); #1;
    tx_we = 1'b0;
  endtask

  task automatic pop_rx();
    @(posedge clk); #1;
    rx_re = 1'b1;
    @(posedge clk); #1;
    rx_re = 1'b0;
  endtask

  task automatic do_start(logic [6:0] a, logic [7:0] wl, logic [7:0] rl);
    @(posedge clk); #1;
    start_i = 1'b1; addr_i = a; wr_len_i = wl; rd_len_i = rl;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(string name, logic exp_nack);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_busy_at_done"}, busy, 0);
      check({name, "_nack_err"}, nack_err, exp_nack);
      @(negedge clk);
      check({name, "_done_pulse"}, done, 0);
    end
    repeat (20) @(negedge clk);
    check({name, "_cmds_left"}, exp_cmd.size(), 0);
  endtask

  task automatic wait_seen(int target);
    int n = 0;
    while (cmd_seen < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_seen", cmd_seen >= target, 1);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_cmd", {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}, 0);
    check("rst_flags", {busy, done, nack_err}, 0);
    check("rst_fifo", {tx_full, rx_empty}, 2'b01);
    @(posedge clk); #1;
    nReset = 1'b1;
    @(negedge clk);
    check("idle_flags", {busy, done, nack_err, tx_full, rx_empty}, 5'b00001);

    // Plain two-byte write with STOP on the last byte.
    push_tx(8'hA0); push_tx(8'hA1);
    exp_cmd.push_back(cmd(1, 0, 0, 1, 0, 8'hA0));
    exp_cmd.push_back(cmd(0, 0, 0, 1, 0, 8'hA0));
    exp_cmd.push_back(cmd(0, 1, 0, 1, 0, 8'hA1));
    do_start(7'h50, 8'd2, 8'd0);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    wait_done("wr2", 1'b0);

    // Write one byte, repeated START, read three.
    push_tx(8'h10);
    rd_q = '{8'h11, 8'h22, 8'h33};
    exp_rx = '{8'h11, 8'h22, 8'h33};
    exp_cmd.push_back(cmd(1, 0, 0, 1, 0, 8'hA0));
    exp_cmd.push_back(cmd(0, 0, 0, 1, 0, 8'h10));
    exp_cmd.push_back(cmd(1, 0, 0, 1, 0, 8'hA1));
    exp_cmd.push_back(cmd(0, 0, 1, 0, 0, 8'h00));
    exp_cmd.push_back(cmd(0, 0, 1, 0, 0, 8'h00));
    exp_cmd.push_back(cmd(0, 1, 1, 0, 1, 8'h00));
    do_start(7'h50, 8'd1, 8'd3);
    wait_done("wr1rd3", 1'b0);
    repeat (3) pop_rx();
    @(negedge clk);
    check("rx_drained", rx_empty, 1);

    // Address probe NACKed.
    nack_q.push_back(1'b1);
    exp_cmd.push_back(cmd(1, 1, 0, 1, 0, 8'hA0));
    do_start(7'h50, 8'd0, 8'd0);
    wait_done("probe_nack", 1'b1);

    // Data NACK on byte 2 of 4: STOP, TX flushed.
    push_tx(8'hB0); push_tx(8'hB1); push_tx(8'hB2); push_tx(8'hB3);
    nack_q = '{1'b0, 1'b0, 1'b1};
    exp_cmd.push_back(cmd(1, 0, 0, 1, 0, 8'hA0));
    exp_cmd.push_back(cmd(0, 0, 0, 1, 0, 8'hB0));
    exp_cmd.push_back(cmd(0, 0, 0, 1, 0, 8'hB1));
    exp_cmd.push_back(cmd(0, 1, 0, 0, 0, 8'h00));
    do_start(7'h50, 8'd4, 8'd0);
    wait_done("data_nack", 1'b1);

    // A leftover B2/B3 would show up here instead of C5; nack_err clears on start.
    push_tx(8'hC5);
    exp_cmd.push_back(cmd(1, 0, 0, 1, 0, 8'hA0));
    exp_cmd.push_back(cmd(0, 1, 0, 1, 0, 8'hC5));
    do_start(7'h50, 8'd1, 8'd0);
    wait_done("after_flush", 1'b0);

    // Read 10 into an 8-deep RX FIFO: stall, then resume after two pops.
    exp_cmd.push_back(cmd(1, 0, 0, 1, 0, 8'hA1));
    for (int i = 1; i <= 10; i++) begin
      rd_q.push_back(8'(i));
      exp_rx.push_back(8'(i));
      exp_cmd.push_back(cmd(0, i == 10, 1, 0, i == 10, 8'h00));
    end
    base = cmd_seen;
    do_start(7'h50, 8'd0, 8'd10);
    wait_seen(base + 9);
    repeat (30) @(negedge clk);
    check("stall_cmds", cmd_seen - base, 9);
    check("stall_busy", busy, 1);
    pop_rx(); pop_rx();
    wait_done("rd10", 1'b0);
    repeat (8) pop_rx();
    @(negedge clk);
    check("rd10_drained", rx_empty, 1);
    check("rd10_rx_left", exp_rx.size(), 0);

    // Fill TX to full, then abort during byte 2 of a 5-byte write.
    for (int i = 1; i <= 8; i++) push_tx(8'hD0 + 8'(i));
    @(negedge clk);
    check("tx_full", tx_full, 1);
    exp_cmd.push_back(cmd(1, 0, 0, 1, 0, 8'hA0));
    exp_cmd.push_back(cmd(0, 0, 0, 1, 0, 8'hD1));
    exp_cmd.push_back(cmd(0, 0, 0, 1, 0, 8'hD2));
    exp_cmd.push_back(cmd(0, 1, 0, 0, 0, 8'h00));
    base = cmd_seen;
    do_start(7'h50, 8'd5, 8'd0);
    wait_seen(base + 3);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_done("abort", 1'b0);
    check("abort_cmds", cmd_seen - base, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
